// File: rtl/register_bank_ab_pkg.sv
// Shared constants and types for the architectural register bank and its dump port.
package register_bank_ab_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Well-known register indices, shared with the RegDst mux
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_30   = 5'd30;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/register_bank_ab_reg_dump_fsm.sv
// Sequencer for the debug dump port: walks indices 0..31 over a valid/ready handshake.
module register_bank_ab_reg_dump_fsm
    import register_bank_ab_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [REG_ADDR_W-1:0] dump_index,
    output logic                  dump_busy,
    output logic                  dump_done
);

    dump_state_e           state;
    dump_state_e           state_next;
    logic [REG_ADDR_W-1:0] index_next;

    // Next state and index; the index saturates at the last register
    always_comb begin
        state_next = state;
        index_next = dump_index;
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = SEND;
                    index_next = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_index == REG_RA) begin
                        state_next = DONE;
                    end else begin
                        index_next = REG_ADDR_W'(dump_index + 1'b1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dump_index <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            state      <= state_next;
            dump_index <= index_next;
            dump_valid <= (state_next == SEND);
            dump_busy  <= (state_next != IDLE);
            dump_done  <= (state_next == DONE);
        end
    end

endmodule

// File: rtl/register_bank_ab.sv
// 32-entry register file with write-first bypassed read ports, A/B operand latches and a dump port.
module register_bank_ab
    import register_bank_ab_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SP_INDEX = 29,
    parameter int unsigned SP_RESET = 227
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] ReadReg1,
    input  logic [REG_ADDR_W-1:0] ReadReg2,
    input  logic                  LoadAB,
    output logic [DATA_W-1:0]     ReadData1,
    output logic [DATA_W-1:0]     ReadData2,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [REG_ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_en;

    assign wr_en = RegWrite && (WriteReg != REG_ZERO);

    // Storage; entry 0 is never written so it reads zero forever
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en) begin
            mem[WriteReg] <= WriteData;
        end
    end

    // Three bypassed read muxes: rs, rt and the dump index
    assign ReadData1 = (wr_en && (WriteReg == ReadReg1))   ? WriteData : mem[ReadReg1];
    assign ReadData2 = (wr_en && (WriteReg == ReadReg2))   ? WriteData : mem[ReadReg2];
    assign dump_data = (wr_en && (WriteReg == dump_index)) ? WriteData : mem[dump_index];

    // Operand latches capture the bypassed values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A <= '0;
            B <= '0;
        end else if (LoadAB) begin
            A <= ReadData1;
            B <= ReadData2;
        end
    end

    register_bank_ab_reg_dump_fsm u_dump (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_index (dump_index),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: doc/register_bank_ab.md
# register_bank_ab

Architectural register file for the multicycle datapath. It consumes the write address chosen by the register-destination mux, together with the write data and write enable. It serves the two read ports, latches the A/B operand registers, and includes a sequential debug dump port. The dump port streams all 32 registers out over a valid/ready handshake for bench and board inspection.

## Interface
Parameters:
- DATA_W, 32, register width
- SP_INDEX, 29, stack-pointer register index
- SP_RESET, 227, reset value of the stack-pointer register

Ports:
- clk  in  1  clock, all state rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- RegWrite  in  1  write enable
- WriteReg  in  5  write address (RegDst mux output)
- WriteData  in  DATA_W  write data
- ReadReg1  in  5  read address port 1 (rs)
- ReadReg2  in  5  read address port 2 (rt)
- LoadAB  in  1  capture ReadData1/2 into A/B
- ReadData1  out  DATA_W  combinational read port 1
- ReadData2  out  DATA_W  combinational read port 2
- A  out  DATA_W  registered operand A
- B  out  DATA_W  registered operand B
- dump_start  in  1  request full-bank dump
- dump_ready  in  1  consumer accepts current word
- dump_valid  out  1  dump word valid
- dump_index  out  5  index of current word
- dump_data  out  DATA_W  contents of dump_index
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after last word accepted

## Operation
- Storage is 32 x DATA_W. Register 0 always reads 0, and writes to it are discarded.
- Write: on a clk edge with RegWrite=1 and WriteReg!=0, mem[WriteReg] <= WriteData.
- Read ports are combinational with write-first bypass. If RegWrite=1, WriteReg==ReadRegN and ReadRegN!=0, then ReadDataN=WriteData; otherwise ReadDataN=mem[ReadRegN].
- A/B: on a clk edge with LoadAB=1, A<=ReadData1 and B<=ReadData2 (bypassed values). Otherwise A/B hold.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start=1 -> SEND, dump_index<=0.
  - SEND: dump_valid=1 and dump_data=bypassed read of dump_index. On valid&&ready: if dump_index==31 -> DONE, else dump_index+1.
  - DONE: dump_done=1 for one cycle, then IDLE.
- dump_busy=1 in SEND and DONE. dump_start is ignored unless in IDLE.
- Normal writes and reads continue during a dump. A word transferred reflects the register contents (with bypass) in its handshake cycle.
- dump_data must stay stable while dump_valid=1 and dump_ready=0, unless that register is written in the meantime; the live value is the decided behaviour.

## Timing
- Reset values: all mem=0 except mem[SP_INDEX]=SP_RESET. A=B=0, state IDLE, dump_index=0, dump_valid=0, dump_busy=0, dump_done=0.
- ReadData1/2 are combinational, zero latency. A/B update 1 cycle after LoadAB.
- The write is visible via the storage path on the next cycle. It is visible via bypass in the same cycle.
- Dump latency: dump_valid is asserted 1 cycle after dump_start is sampled in IDLE. With dump_ready held at 1, the 32 words take 32 cycles, followed by dump_done in the next cycle. A full dump therefore takes 34 cycles from start to IDLE.
- Simultaneous write and LoadAB to the same index: A/B capture the new WriteData.
- Simultaneous write to dump_index during a handshake: the transferred word is the new WriteData.
- Reset asserted mid-dump: the FSM goes to IDLE and dump outputs deassert immediately (asynchronously). No dump_done pulse is produced.
- Bounds: dump_index saturates at 31 and never wraps within a dump. WriteReg/ReadReg span the full 5-bit range with no out-of-range case.

## Structure
- Shared package: constants REG_ZERO=0, REG_SP=29, REG_30=30, REG_RA=31 (these are also used by the RegDst mux), plus the dump state enum IDLE/SEND/DONE.
- One sub-module: reg_dump_fsm. It holds the state, the index counter and the handshake outputs, and drives dump_index into the bank's third read mux.
- The top level holds storage, bypass logic and the A/B registers.

## Test plan
- Reset -> all ReadData=0 except ReadReg1=29 gives 227. A=B=0. dump_busy=0.
- Write reg 5 = 32'hDEADBEEF with ReadReg1=5 in the same cycle -> ReadData1=DEADBEEF combinationally. With LoadAB=1, A=DEADBEEF next cycle.
- Write reg 0 = 32'hFFFFFFFF -> ReadData of reg 0 stays 0, including the bypass cycle.
- Write regs 31/30 with PC-like values, then dump with dump_ready=1 -> 32 words with indices 0..31 in order. Index 29 gives 227, 30/31 give the written values. dump_done pulses at cycle 33 after start.
- Dump with dump_ready toggling 1,0,0,1 -> index and data hold while not ready, no word skipped or duplicated. dump_start during busy is ignored.
- Assert reset at dump_index=10 -> dump_valid=0 and state IDLE immediately, no dump_done. All registers reset, register 29 returns to 227.
